// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter and sequencer that lets NUM_REQ cache
// controllers share one single-port main memory. One transaction is in flight
// at a time: IDLE (arbitrate/latch) -> ISSUE -> CAPTURE -> ACK -> IDLE.
module mem_bus_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           resp_rdata,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W:0] NUM_REQ_EXT = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] RR_RESET = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [ID_W-1:0]        r_rr_ptr;
    logic [NUM_REQ-1:0]     r_ack;
    logic [NUM_REQ-1:0]     r_grant;
    logic                   r_busy;
    logic                   r_mem_we;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [DATA_W-1:0]      r_mem_wdata;
    logic [DATA_W-1:0]      r_resp_rdata;

    logic                   w_found;
    logic [ID_W-1:0]        w_win_id;
    logic [ADDR_W-1:0]      w_win_addr;
    logic [DATA_W-1:0]      w_win_wdata;
    logic                   w_win_we;
    logic [NUM_REQ-1:0]     w_win_onehot;

    logic                   w_latch;
    logic                   w_capture;
    logic [NUM_REQ-1:0]     w_ack_nxt;
    logic [NUM_REQ-1:0]     w_grant_nxt;
    logic                   w_mem_we_nxt;

    // Round-robin search: first set req bit after r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin : arb
        logic [ID_W:0] w_cand;
        w_found  = 1'b0;
        w_win_id = '0;
        w_cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_cand >= NUM_REQ_EXT) begin
                w_cand = w_cand - NUM_REQ_EXT;
            end
            if (!w_found && req[w_cand[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_win_id = w_cand[ID_W-1:0];
            end
        end
    end

    // Select the winner's payload; non-winning inputs never propagate further.
    always_comb begin
        w_win_addr   = '0;
        w_win_wdata  = '0;
        w_win_we     = 1'b0;
        w_win_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win_id == ID_W'(i)) begin
                w_win_addr      = req_addr[i*ADDR_W +: ADDR_W];
                w_win_wdata     = req_wdata[i*DATA_W +: DATA_W];
                w_win_we        = req_we[i];
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        w_ack_nxt    = '0;
        w_grant_nxt  = r_grant;
        w_mem_we_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_latch      = 1'b1;
                    w_grant_nxt  = w_win_onehot;
                    w_mem_we_nxt = w_win_we;
                    w_state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_capture   = 1'b1;
                w_ack_nxt   = r_grant;
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered handshake and memory-control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack    <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_mem_we <= 1'b0;
        end else begin
            r_ack    <= w_ack_nxt;
            r_grant  <= w_grant_nxt;
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_mem_we <= w_mem_we_nxt;
        end
    end

    // Latched winner payload and round-robin pointer; address held until next latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= RR_RESET;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_latch) begin
            r_rr_ptr    <= w_win_id;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
        end
    end

    // Capture the registered memory read data during CAPTURE; stable through ACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_rdata <= '0;
        end else if (w_capture) begin
            r_resp_rdata <= mem_rdata;
        end
    end

    assign ack        = r_ack;
    assign grant      = r_grant;
    assign busy       = r_busy;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with a registered read-before-write memory model.
module tb_mem_bus_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 64;
    localparam logic [63:0] BASE    = 64'hC0DE_0000_0000_0000;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         resp_rdata;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_rdata;

    logic [DATA_W-1:0]         mem [0:(1<<ADDR_W)-1];
    logic                      mem_init;

    int n_checks = 0;
    int n_pass   = 0;

    mem_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .resp_rdata(resp_rdata), .grant(grant),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: every word defaults to BASE|addr, word 0x010 is preloaded specially.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int a = 0; a < (1 << ADDR_W); a++) mem[a] <= BASE | 64'(a);
            mem[9'h010] <= 64'h1122334455667788;
        end else begin
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; req = '0; req_we = '0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        #3;
        n_checks++; if (ack !== 2'b00) $display("FAIL reset_ack: got %b want 00", ack); else n_pass++;
        n_checks++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 9'h000) $display("FAIL reset_mem_addr: got %h want 000", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 64'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (resp_rdata !== 64'h0) $display("FAIL reset_resp: got %h want 0", resp_rdata); else n_pass++;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        req_addr[0 +: ADDR_W] = 9'h010; req_we[0] = 1'b0; req[0] = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick;
            n_checks++; if (mem_we !== 1'b0) $display("FAIL rd_mem_we t%0d: got %b want 0", t, mem_we); else n_pass++;
            n_checks++; if (ack !== ((t == 3) ? 2'b01 : 2'b00)) $display("FAIL rd_ack t%0d: got %b", t, ack); else n_pass++;
            if (t == 1) begin
                n_checks++; if (mem_addr !== 9'h010) $display("FAIL rd_addr: got %h want 010", mem_addr); else n_pass++;
                n_checks++; if (grant !== 2'b01) $display("FAIL rd_grant: got %b want 01", grant); else n_pass++;
                n_checks++; if (busy !== 1'b1) $display("FAIL rd_busy: got %b want 1", busy); else n_pass++;
            end
        end
        n_checks++; if (resp_rdata !== 64'h1122334455667788) $display("FAIL rd_data: got %h want 1122334455667788", resp_rdata); else n_pass++;
        req = '0;
        tick;
        n_checks++; if (busy !== 1'b0 || grant !== 2'b00 || ack !== 2'b00)
            $display("FAIL rd_idle: got busy=%b grant=%b ack=%b want 0/00/00", busy, grant, ack); else n_pass++;
    endtask

    task automatic test_write_read;
        int we_cycles;
        we_cycles = 0;
        req_addr[ADDR_W +: ADDR_W] = 9'h105; req_wdata[DATA_W +: DATA_W] = 64'hDEADBEEFCAFEF00D;
        req_we[1] = 1'b1; req[1] = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick;
            if (mem_we) we_cycles++;
            if (t == 1) begin
                n_checks++; if (mem_we !== 1'b1 || mem_addr !== 9'h105) $display("FAIL wr_issue: got we=%b addr=%h want 1/105", mem_we, mem_addr); else n_pass++;
                n_checks++; if (mem_wdata !== 64'hDEADBEEFCAFEF00D) $display("FAIL wr_wdata: got %h", mem_wdata); else n_pass++;
                n_checks++; if (grant !== 2'b10) $display("FAIL wr_grant: got %b want 10", grant); else n_pass++;
            end
        end
        n_checks++; if (ack !== 2'b10) $display("FAIL wr_ack: got %b want 10", ack); else n_pass++;
        n_checks++; if (resp_rdata !== (BASE | 64'h105)) $display("FAIL wr_prewrite: got %h want %h", resp_rdata, BASE | 64'h105); else n_pass++;
        req = '0; req_we = '0;
        tick;
        if (mem_we) we_cycles++;
        n_checks++; if (we_cycles != 1) $display("FAIL wr_we_cycles: got %0d want 1", we_cycles); else n_pass++;
        req[1] = 1'b1;
        tick; tick; tick;
        n_checks++; if (ack !== 2'b10) $display("FAIL rb_ack: got %b want 10", ack); else n_pass++;
        n_checks++; if (resp_rdata !== 64'hDEADBEEFCAFEF00D) $display("FAIL rb_data: got %h want deadbeefcafef00d", resp_rdata); else n_pass++;
        req = '0;
        tick;
    endtask

    task automatic test_contention;
        logic [1:0]  exp_grant, exp_ack;
        logic [63:0] exp_data;
        int          owner;
        reset = 1'b1; req_we = '0;
        req_addr[0 +: ADDR_W] = 9'h030; req_addr[ADDR_W +: ADDR_W] = 9'h131;
        req = 2'b11;
        tick; tick;
        reset = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            tick;
            owner     = ((t - 1) / 4) % 2;
            exp_grant = (t % 4 == 0) ? 2'b00 : ((owner == 1) ? 2'b10 : 2'b01);
            exp_ack   = (t % 4 == 3) ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
            n_checks++; if (grant !== exp_grant) $display("FAIL cont_grant t%0d: got %b want %b", t, grant, exp_grant); else n_pass++;
            n_checks++; if (ack !== exp_ack) $display("FAIL cont_ack t%0d: got %b want %b", t, ack, exp_ack); else n_pass++;
            if (t % 4 == 3) begin
                exp_data = BASE | ((owner == 1) ? 64'h131 : 64'h030);
                n_checks++; if (resp_rdata !== exp_data) $display("FAIL cont_data t%0d: got %h want %h", t, resp_rdata, exp_data); else n_pass++;
            end
        end
        req = '0;
        tick; tick;
    endtask

    task automatic test_late_request;
        do_reset;
        req_addr[0 +: ADDR_W] = 9'h040; req_addr[ADDR_W +: ADDR_W] = 9'h141;
        req[0] = 1'b1;
        tick; tick;
        req[1] = 1'b1;
        tick;
        n_checks++; if (ack !== 2'b01) $display("FAIL late_ack0: got %b want 01", ack); else n_pass++;
        n_checks++; if (resp_rdata !== (BASE | 64'h040)) $display("FAIL late_data0: got %h", resp_rdata); else n_pass++;
        req[0] = 1'b0;
        for (int t = 4; t <= 7; t++) begin
            tick;
            n_checks++; if (ack !== ((t == 7) ? 2'b10 : 2'b00)) $display("FAIL late_ack t%0d: got %b", t, ack); else n_pass++;
        end
        n_checks++; if (resp_rdata !== (BASE | 64'h141)) $display("FAIL late_data1: got %h", resp_rdata); else n_pass++;
        req = '0;
        tick;
    endtask

    task automatic test_reset_mid_write;
        do_reset;
        req_addr[0 +: ADDR_W] = 9'h020; req_wdata[0 +: DATA_W] = 64'h0BAD_0BAD_0BAD_0BAD;
        req_we[0] = 1'b1; req[0] = 1'b1;
        tick;
        n_checks++; if (mem_we !== 1'b1) $display("FAIL mid_issue_we: got %b want 1", mem_we); else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL mid_we_drop: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (grant !== 2'b00 || busy !== 1'b0) $display("FAIL mid_state: got grant=%b busy=%b", grant, busy); else n_pass++;
        req = '0; req_we = '0;
        tick; tick;
        reset = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick;
            n_checks++; if (ack !== 2'b00 || busy !== 1'b0) $display("FAIL mid_noack t%0d: got ack=%b busy=%b", t, ack, busy); else n_pass++;
        end
        req_addr[0 +: ADDR_W] = 9'h050; req_addr[ADDR_W +: ADDR_W] = 9'h151;
        req = 2'b11;
        tick;
        n_checks++; if (grant !== 2'b01) $display("FAIL mid_first_grant: got %b want 01", grant); else n_pass++;
        tick; tick;
        n_checks++; if (ack !== 2'b01) $display("FAIL mid_first_ack: got %b want 01", ack); else n_pass++;
        req = '0;
        tick; tick;
    endtask

    task automatic test_withdrawn;
        do_reset;
        req_addr[0 +: ADDR_W] = 9'h060; req_addr[ADDR_W +: ADDR_W] = 9'h161;
        req[0] = 1'b1;
        tick;
        req[1] = 1'b1;
        tick;
        req[1] = 1'b0;
        tick;
        n_checks++; if (ack !== 2'b01) $display("FAIL wd_ack0: got %b want 01", ack); else n_pass++;
        req = '0;
        for (int t = 4; t <= 9; t++) begin
            tick;
            n_checks++; if (ack !== 2'b00) $display("FAIL wd_ack t%0d: got %b want 00", t, ack); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL wd_busy t%0d: got %b want 0", t, busy); else n_pass++;
            n_checks++; if (grant !== 2'b00) $display("FAIL wd_grant t%0d: got %b want 00", t, grant); else n_pass++;
        end
    endtask

    initial begin
        mem_init = 1'b1;
        reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        tick;
        mem_init = 1'b0;
        test_reset;
        test_single_read;
        test_write_read;
        test_contention;
        test_late_request;
        test_reset_mid_write;
        test_withdrawn;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
